pitch_sweep_ctrl: RTL

//  Sequencer for the two-tap crossfading delay datapath of the voice pitch changer.

---
 rtl/pitch_sweep_ctrl_pkg.sv | 39 +++
 rtl/pitch_sweep_ctrl_if.sv | 25 ++
 rtl/pitch_sweep_ctrl_dv_edge_sync.sv | 29 ++
 rtl/pitch_sweep_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/pitch_sweep_ctrl_pkg.sv
// Shared types, widths and helpers for the pitch-changer sweep controller.
// Holds the FSM encoding, tap spacing, gain constants and the crossfade gain mapping.
package pitch_sweep_ctrl_pkg;

  localparam int CTR_W   = 9;
  localparam int GAIN_W  = 8;
  localparam int PRESC_W = 3;

  localparam logic [CTR_W-1:0]  K_OFFSET   = 9'd128;
  localparam logic [GAIN_W-1:0] G_FULL     = 8'h7F;
  localparam logic [9:0]        ADC_OFFSET = 10'h188;
  localparam logic [9:0]        DAC_OFFSET = 10'h200;

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_ARM    = 2'd1,
    ST_SWEEP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [GAIN_W-1:0] ga;
    logic [GAIN_W-1:0] gb;
  } gains_t;

  // Triangular crossfade: c + ~c = 7F keeps ga + gb constant in every region.
  function automatic gains_t tap_gains(input logic [CTR_W-1:0] ctr);
    gains_t     g;
    logic [6:0] c;
    c = ctr[6:0];
    case (ctr[8:7])
      2'b00: begin g.ga = '0;        g.gb = G_FULL;     end
      2'b01: begin g.ga = {1'b0, c};  g.gb = {1'b0, ~c}; end
      2'b10: begin g.ga = G_FULL;     g.gb = '0;         end
      default: begin g.ga = {1'b0, ~c}; g.gb = {1'b0, c}; end
    endcase
    return g;
  endfunction

endpackage

// File: rtl/pitch_sweep_ctrl_if.sv
// Bundle between the ADC interface, the sweep controller and the delay/mult pair.
// master = controller side, slave = surrounding datapath side.
interface pitch_sweep_ctrl_if;
  import pitch_sweep_ctrl_pkg::*;

  logic              data_valid;
  logic [3:0]        mode;
  logic              load;
  logic [CTR_W-1:0]  ka;
  logic [CTR_W-1:0]  kb;
  logic [GAIN_W-1:0] ga;
  logic [GAIN_W-1:0] gb;
  logic              bypass;

  modport master (
    input  data_valid, mode,
    output load, ka, kb, ga, gb, bypass
  );

  modport slave (
    output data_valid, mode,
    input  load, ka, kb, ga, gb, bypass
  );

endinterface

// File: rtl/pitch_sweep_ctrl_dv_edge_sync.sv
// Brings the asynchronous ADC data_valid level into sysclk and emits one
// registered tick per rising edge of that level.
module pitch_sweep_ctrl_dv_edge_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic s1_q, s2_q, s3_q, tick_q;

  // tick is registered so that load (one flop later) lands after edge k+3.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= async_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      tick_q <= s2_q & ~s3_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pitch_sweep_ctrl.sv
// Sweep sequencer for the two-tap crossfading delay: turns sample ticks into
// load pulses, steps the sweep counter and registers tap delays and gains.
module pitch_sweep_ctrl
  import pitch_sweep_ctrl_pkg::*;
(
  input  logic                sysclk,
  input  logic                reset,
  pitch_sweep_ctrl_if.master  bus
);

  state_e             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               load_q;
  logic [CTR_W-1:0]   ka_q, kb_q;
  gains_t             gains_q;
  logic               tick;
  logic               mode_zero;
  logic [PRESC_W-1:0] presc_reload;

  pitch_sweep_ctrl_dv_edge_sync u_sync (
    .sysclk   (sysclk),
    .reset    (reset),
    .async_in (bus.data_valid),
    .tick     (tick)
  );

  assign mode_zero    = (bus.mode == 4'd0);
  // P - 1 = 7 - mode[3:1], which is simply the bitwise complement.
  assign presc_reload = ~bus.mode[3:1];

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    presc_d = presc_q;
    case (state_q)
      ST_BYPASS: begin
        ctr_d   = '0;
        presc_d = '0;
        if (!mode_zero) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (tick) begin
          presc_d = presc_reload;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (tick) begin
          if (presc_q == '0) begin
            ctr_d   = bus.mode[0] ? ctr_q - CTR_W'(1) : ctr_q + CTR_W'(1);
            presc_d = presc_reload;
          end else begin
            presc_d = presc_q - PRESC_W'(1);
          end
        end
      end
      default: state_d = ST_BYPASS;
    endcase
    // Bypass request overrides any step due on this cycle.
    if (mode_zero) begin
      state_d = ST_BYPASS;
      ctr_d   = '0;
      presc_d = '0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BYPASS;
      ctr_q   <= '0;
      presc_q <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      presc_q <= presc_d;
      load_q  <= tick;
    end
  end

  // Tap outputs follow ctr by one cycle; reset values match ctr = 0.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      ka_q    <= 9'h180;
      kb_q    <= 9'h080;
      gains_q <= '{ga: 8'h00, gb: G_FULL};
    end else begin
      ka_q    <= ctr_q - K_OFFSET;
      kb_q    <= ctr_q + K_OFFSET;
      gains_q <= tap_gains(ctr_q);
    end
  end

  assign bus.load   = load_q;
  assign bus.ka     = ka_q;
  assign bus.kb     = kb_q;
  assign bus.ga     = gains_q.ga;
  assign bus.gb     = gains_q.gb;
  assign bus.bypass = (state_q == ST_BYPASS);

endmodule
